// File: rtl/inv_mix_columns_seq.sv
// Column-serial AES InvMixColumns engine with valid/ready handshakes.
// Transforms COLS_PER_CYCLE columns per clock; bypass passes the state through.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] state_in,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] state_out
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
          COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // With 4 columns per cycle the step wraps to 0 and the last start is 0.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m09(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] m0b(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] m0d(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] m0e(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {m0e(a0) ^ m0b(a1) ^ m0d(a2) ^ m09(a3),
                m09(a0) ^ m0e(a1) ^ m0b(a2) ^ m0d(a3),
                m0d(a0) ^ m09(a1) ^ m0e(a2) ^ m0b(a3),
                m0b(a0) ^ m0d(a1) ^ m09(a2) ^ m0e(a3)};
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [0:127] state_q, state_d;
    logic         byp_q, byp_d;
    logic [0:127] out_q, out_d;
    logic [0:127] work;

    always_comb begin
        work = state_q;
        for (int j = 0; j < 4; j++) begin
            if (j >= int'(cnt_q) &&
                j < int'(cnt_q) + COLS_PER_CYCLE && !byp_q) begin
                work[j*32 +: 32] = inv_col(state_q[j*32 +: 32]);
            end
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        byp_d   = byp_q;
        out_d   = out_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = state_in;
                    byp_d   = in_bypass;
                    cnt_d   = '0;
                    fsm_d   = S_CALC;
                end
            end
            S_CALC: begin
                state_d = work;
                cnt_d   = cnt_q + CNT_STEP;
                if (cnt_q == CNT_LAST) begin
                    out_d = work;
                    fsm_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            cnt_q   <= '0;
            state_q <= '0;
            byp_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            byp_q   <= byp_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (fsm_q == S_IDLE);
    assign out_valid = (fsm_q == S_DONE);
    assign state_out = out_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq at 1, 2 and 4 columns per cycle.
// Random round trips go through a forward MixColumns model first.
module tb_inv_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [0:127] st_in     [3];
    logic         byp       [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [0:127] st_out    [3];

    int total = 0;
    int bad = 0;

    localparam logic [127:0] KV_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] KV_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] BY_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_mix_columns_seq #(
            .COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .state_in (st_in[g]),
            .in_bypass(byp[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .state_out(st_out[g])
        );
    end

    function automatic logic [7:0] x2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3,
                x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3)};
    endfunction

    function automatic logic [127:0] fwd_state(input logic [127:0] d);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = fwd_col(d[127-32*c -: 32]);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where out_valid is seen.
    task automatic start_op(input int k, input logic [127:0] d,
                            input logic b, output int lat);
        int n;
        in_valid[k] = 1'b1;
        st_in[k] = d;
        byp[k] = b;
        n = 0;
        while (in_ready[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 128'(in_ready[k]), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (out_valid[k] !== 1'b1 && lat < 50);
        check("out_wait", 128'(out_valid[k]), 128'd1);
    endtask

    task automatic handoff(input int k);
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[k] = 1'b0;
        check("handoff_ov", 128'(out_valid[k]), 128'd0);
        check("handoff_ir", 128'(in_ready[k]), 128'd1);
    endtask

    initial begin
        int lat;
        int exp_lat;
        int seen;
        logic [127:0] d;
        logic [127:0] hold;

        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0;
            st_in[k] = '0;
            byp[k] = 1'b0;
            out_ready[k] = 1'b0;
        end

        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_in_ready", 128'(in_ready[k]), 128'd1);
            check("rst_out_valid", 128'(out_valid[k]), 128'd0);
            check("rst_state_out", st_out[k], 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Known vector and bypass on every width.
        for (int k = 0; k < 3; k++) begin
            exp_lat = (k == 0) ? 4 : ((k == 1) ? 2 : 1);
            start_op(k, KV_IN, 1'b0, lat);
            check("kv_result", st_out[k], KV_OUT);
            check("kv_latency", 128'(lat), 128'(exp_lat));
            handoff(k);
            start_op(k, BY_IN, 1'b1, lat);
            check("byp_result", st_out[k], BY_IN);
            check("byp_latency", 128'(lat), 128'(exp_lat));
            handoff(k);
        end

        // Backpressure with a second state queued behind the first.
        start_op(0, BY_IN, 1'b1, lat);
        hold = st_out[0];
        in_valid[0] = 1'b1;
        st_in[0] = KV_IN;
        byp[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid[0]), 128'd1);
            check("bp_state_out", st_out[0], hold);
            check("bp_in_ready", 128'(in_ready[0]), 128'd0);
        end
        handoff(0);
        start_op(0, KV_IN, 1'b0, lat);
        check("bp_queued_result", st_out[0], KV_OUT);
        check("bp_queued_latency", 128'(lat), 128'd4);
        handoff(0);

        // Random round trips through the forward transform.
        for (int k = 0; k < 3; k++) begin
            exp_lat = (k == 0) ? 4 : ((k == 1) ? 2 : 1);
            for (int i = 0; i < 200; i++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                start_op(k, fwd_state(d), 1'b0, lat);
                check("rt_result", st_out[k], d);
                check("rt_latency", 128'(lat), 128'(exp_lat));
                handoff(k);
            end
        end

        // Abort mid-calculation after two columns.
        in_valid[0] = 1'b1;
        st_in[0] = KV_IN;
        byp[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 128'(in_ready[0]), 128'd1);
        check("abort_out_valid", 128'(out_valid[0]), 128'd0);
        check("abort_state_out", st_out[0], 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid[0] === 1'b1) seen++;
        end
        check("abort_no_output", 128'(seen), 128'd0);
        start_op(0, KV_IN, 1'b0, lat);
        check("post_abort_result", st_out[0], KV_OUT);
        check("post_abort_latency", 128'(lat), 128'd4);
        handoff(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
